// File: rtl/dff_rr_arbiter_if.sv
// Request/grant bus between N requesters and the shared-register arbiter.
interface dff_rr_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned OWN_W = $clog2(N);

    logic [N-1:0]     req;
    logic [N-1:0]     lock;
    logic [N*W-1:0]   din;
    logic [N-1:0]     gnt;
    logic [OWN_W-1:0] owner;
    logic             busy;
    logic [W-1:0]     q;

    // Requester side drives requests and data, observes grant and register.
    modport master (
        output req, lock, din,
        input  gnt, owner, busy, q
    );

    // Arbiter side owns the register and grant outputs.
    modport slave (
        input  req, lock, din,
        output gnt, owner, busy, q
    );
endinterface

// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter owning one shared W-bit register; a locked owner may
// keep it for up to MAX_HOLD consecutive cycles. All outputs are flops.
module dff_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    dff_rr_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(N);
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_gnt;
    logic [PTR_W-1:0]   r_owner;
    logic               r_busy;
    logic [W-1:0]       r_q;

    state_t             w_state_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [N-1:0]       w_gnt_nxt;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic               w_busy_nxt;
    logic [W-1:0]       w_q_nxt;
    logic               w_found;
    logic [PTR_W-1:0]   w_sel;
    logic [PTR_W-1:0]   w_idx;
    logic               w_cont;

    // State and output register bank; reset clears everything at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= w_busy_nxt;
            r_q     <= w_q_nxt;
        end
    end

    // Next-state decision: locked continuation, else round-robin grant, else idle.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = '0;
        w_gnt_nxt   = '0;
        w_owner_nxt = r_owner;
        w_busy_nxt  = 1'b0;
        w_q_nxt     = r_q;
        w_found     = 1'b0;
        w_sel       = '0;
        w_idx       = '0;

        // First requester at or after the pointer, wrapping modulo N.
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = PTR_W'((32'(r_ptr) + k) % N);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end

        w_cont = (r_state != ST_IDLE) && bus.req[r_owner] && bus.lock[r_owner]
                 && (r_cnt < CNT_W'(MAX_HOLD));

        if (w_cont) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_gnt_nxt   = r_gnt;
            w_busy_nxt  = 1'b1;
            w_q_nxt     = bus.din[32'(r_owner) * W +: W];
        end else if (w_found) begin
            w_state_nxt = ST_GRANT;
            w_cnt_nxt   = CNT_W'(1);
            w_gnt_nxt   = N'(1) << w_sel;
            w_owner_nxt = w_sel;
            w_busy_nxt  = 1'b1;
            w_q_nxt     = bus.din[32'(w_sel) * W +: W];
            w_ptr_nxt   = PTR_W'((32'(w_sel) + 32'd1) % N);
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.owner = r_owner;
    assign bus.busy  = r_busy;
    assign bus.q     = r_q;
endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Scoreboard bench: the driver pushes model expectations, the monitor pops
// and compares one entry after every rising edge.
module tb_dff_rr_arbiter;
    localparam int unsigned N        = 4;
    localparam int unsigned W        = 8;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned PW       = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dff_rr_arbiter_if #(.N(N), .W(W)) bus ();

    dff_rr_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [N-1:0]  gnt;
        logic [PW-1:0] owner;
        logic          busy;
        logic [W-1:0]  q;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    // Behavioural model: who owns the register, for how long, and where the
    // rotation starts next.
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    int          m_run;
    logic [W-1:0] m_q;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_run = 0; m_q = '0;
    endfunction

    function automatic void model_step(input logic r, input logic [N-1:0] rq,
                                       input logic [N-1:0] lk, input logic [N*W-1:0] d);
        int win;
        win = -1;
        if (r) begin
            model_reset();
        end else if (m_busy && rq[m_owner] && lk[m_owner] && m_run < int'(MAX_HOLD)) begin
            m_run = m_run + 1;
            m_q   = d[m_owner*W +: W];
        end else begin
            for (int k = 0; k < int'(N); k++)
                if (win < 0 && rq[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            if (win >= 0) begin
                m_busy  = 1;
                m_owner = win;
                m_run   = 1;
                m_q     = d[win*W +: W];
                m_ptr   = (win + 1) % N;
            end else begin
                m_busy = 0;
                m_run  = 0;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.gnt   = m_busy ? N'(1) << m_owner : '0;
        e.owner = PW'(m_owner);
        e.busy  = m_busy;
        e.q     = m_q;
        return e;
    endfunction

    task automatic cycle(input logic r, input logic [N-1:0] rq,
                         input logic [N-1:0] lk, input logic [N*W-1:0] d);
        @(negedge clk);
        rst      = r;
        bus.req  = rq;
        bus.lock = lk;
        bus.din  = d;
        model_step(r, rq, lk, d);
        sb.push_back(model_out());
    endtask

    function automatic logic [N*W-1:0] rand_din();
        logic [N*W-1:0] d;
        for (int i = 0; i < int'(N); i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    // Monitor: compare registered outputs just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("gnt",   32'(bus.gnt),   32'(e.gnt));
                chk("owner", 32'(bus.owner), 32'(e.owner));
                chk("busy",  32'(bus.busy),  32'(e.busy));
                chk("q",     32'(bus.q),     32'(e.q));
                chk("onehot_gnt", 32'($countones(bus.gnt) <= 1), 32'(1));
                chk("gnt_vs_busy", 32'(bus.gnt != '0), 32'(bus.busy));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0] d;
        rst = 1'b1;
        bus.req = '0; bus.lock = '0; bus.din = '0;
        model_reset();
        #2;
        chk("rst_gnt",  32'(bus.gnt),  32'(0));
        chk("rst_q",    32'(bus.q),    32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_owner",32'(bus.owner),32'(0));

        // Reset held with random traffic, then release idle.
        repeat (2) cycle(1'b1, N'($urandom), N'($urandom), rand_din());
        repeat (3) cycle(1'b0, '0, '0, rand_din());

        // Single request, then drop.
        d = '0; d[0 +: W] = 8'hA5;
        cycle(1'b0, 4'b0001, '0, d);
        cycle(1'b0, 4'b0000, '0, rand_din());

        // Plain round robin across all requesters.
        d = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (5) cycle(1'b0, 4'b1111, 4'b0000, d);

        // Lock cap: requester 0 locked against requester 1.
        repeat (15) cycle(1'b0, 4'b0011, 4'b0001, rand_din());
        cycle(1'b0, '0, '0, rand_din());

        // Sole locked requester with incrementing data.
        for (int i = 0; i < 12; i++) begin
            d = '0; d[2*W +: W] = W'(i + 8'h40);
            cycle(1'b0, 4'b0100, 4'b0100, d);
        end
        cycle(1'b0, '0, '0, rand_din());

        // Async reset during the third locked cycle.
        repeat (3) cycle(1'b0, 4'b0001, 4'b0001, rand_din());
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_gnt",  32'(bus.gnt),  32'(0));
        chk("async_q",    32'(bus.q),    32'(0));
        chk("async_busy", 32'(bus.busy), 32'(0));
        cycle(1'b1, 4'b0001, 4'b0001, rand_din());
        cycle(1'b0, 4'b1000, '0, rand_din());
        cycle(1'b0, 4'b1111, '0, rand_din());
        cycle(1'b0, '0, '0, rand_din());

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 59) == 0), N'($urandom), N'($urandom), rand_din());

        cycle(1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
